// File: rtl/lcd_multi_line_feed.sv
// Timed Moore FSM that feeds clear / per-line write requests to the LCD command driver.
// Optional command-acknowledge timeout: define LCD_FEED_CMD_TIMEOUT_EN.
module lcd_multi_line_feed #(
  parameter int unsigned parm_line_count      = 2,
  parameter int unsigned parm_cmd_delay_ticks = 2500,
  parameter int unsigned parm_refresh_ticks   = 490000,
  parameter int unsigned parm_timeout_ticks   = 25000
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rst_20mhz,
  input  logic       i_ce_2_5mhz,
  input  logic       i_lcd_command_ready,
  input  logic       i_feed_enable,
  input  logic       i_refresh_request,
  output logic       o_lcd_wr_clear_display,
  output logic [3:0] o_lcd_wr_text_line,
  output logic [1:0] o_lcd_line_index,
  output logic       o_lcd_feed_is_idle,
  output logic [7:0] o_refresh_count,
  output logic       o_cmd_timeout
);

  localparam int unsigned DLY_MAX = (parm_cmd_delay_ticks > parm_refresh_ticks) ?
                                    parm_cmd_delay_ticks : parm_refresh_ticks;
`ifdef LCD_FEED_CMD_TIMEOUT_EN
  // Timer must be able to reach the timeout threshold when it exceeds both delays.
  localparam int unsigned TMR_MAX = (parm_timeout_ticks > DLY_MAX) ? parm_timeout_ticks : DLY_MAX;
  localparam logic [23:0] TO_LAST = 24'(parm_timeout_ticks - 1);
`else
  localparam int unsigned TMR_MAX = DLY_MAX;
`endif
  localparam logic [23:0] TMR_SAT   = 24'(TMR_MAX);
  localparam logic [23:0] CMD_LAST  = 24'(parm_cmd_delay_ticks - 1);
  localparam logic [23:0] REF_LAST  = 24'(parm_refresh_ticks - 1);
  localparam logic [1:0]  IDX_LAST  = 2'(parm_line_count - 1);
  localparam logic [3:0]  LINE_MASK = 4'((1 << parm_line_count) - 1);

  typedef enum logic [2:0] {
    ST_PAUSE,
    ST_CLEAR_RUN,
    ST_CLEAR_DLY,
    ST_CLEAR_WAIT,
    ST_LINE_RUN,
    ST_LINE_DLY,
    ST_LINE_WAIT,
    ST_REFRESH_DLY
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [1:0]  idx_q, idx_d;
  logic        refresh_flag_q;
  logic [7:0]  count_q;
  logic        inc_cnt;
  logic        clear_q;
  logic [3:0]  line_q, line_d;
  logic        idle_q;
`ifdef LCD_FEED_CMD_TIMEOUT_EN
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inc_cnt = 1'b0;
`ifdef LCD_FEED_CMD_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_PAUSE:       if (i_feed_enable && i_lcd_command_ready) state_d = ST_CLEAR_RUN;
      ST_CLEAR_RUN:   if (!i_lcd_command_ready) state_d = ST_CLEAR_DLY;
      ST_CLEAR_DLY:   if (timer_q == CMD_LAST) state_d = ST_CLEAR_WAIT;
      ST_CLEAR_WAIT:
        if (i_lcd_command_ready) begin
          idx_d   = '0;
          state_d = ST_LINE_RUN;
        end
      ST_LINE_RUN:    if (!i_lcd_command_ready) state_d = ST_LINE_DLY;
      ST_LINE_DLY:
        if (timer_q == CMD_LAST) begin
          if (idx_q < IDX_LAST) begin
            state_d = ST_LINE_WAIT;
          end else begin
            state_d = ST_REFRESH_DLY;
            inc_cnt = 1'b1;
          end
        end
      ST_LINE_WAIT:
        if (i_lcd_command_ready) begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_LINE_RUN;
        end
      ST_REFRESH_DLY: if (timer_q == REF_LAST || refresh_flag_q) state_d = ST_PAUSE;
      default:        state_d = ST_PAUSE;
    endcase
`ifdef LCD_FEED_CMD_TIMEOUT_EN
    if ((state_q == ST_CLEAR_RUN || state_q == ST_LINE_RUN) &&
        i_lcd_command_ready && timer_q == TO_LAST) begin
      state_d   = ST_PAUSE;
      timeout_d = 1'b1;
    end
`endif
  end

  always_comb begin
    if (state_d != state_q)     timer_d = '0;
    else if (timer_q < TMR_SAT) timer_d = timer_q + 24'd1;
    else                        timer_d = timer_q;
  end

  // Outputs are registered from the next state so they track the state register exactly.
  assign line_d = (state_d == ST_LINE_RUN) ? ((4'b0001 << idx_d) & LINE_MASK) : '0;

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q        <= ST_PAUSE;
      timer_q        <= '0;
      idx_q          <= '0;
      refresh_flag_q <= 1'b0;
      count_q        <= '0;
      clear_q        <= 1'b0;
      line_q         <= '0;
      idle_q         <= 1'b0;
`ifdef LCD_FEED_CMD_TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      // A request on the same clock as the clear keeps the flag set.
      if (i_refresh_request)
        refresh_flag_q <= 1'b1;
      else if (i_ce_2_5mhz && state_d == ST_CLEAR_RUN && state_q != ST_CLEAR_RUN)
        refresh_flag_q <= 1'b0;
      if (i_ce_2_5mhz) begin
        state_q <= state_d;
        timer_q <= timer_d;
        idx_q   <= idx_d;
        if (inc_cnt) count_q <= count_q + 8'd1;
        clear_q <= (state_d == ST_CLEAR_RUN);
        line_q  <= line_d;
        idle_q  <= (state_d == ST_REFRESH_DLY);
`ifdef LCD_FEED_CMD_TIMEOUT_EN
        timeout_q <= timeout_d;
`endif
      end
    end
  end

  assign o_lcd_wr_clear_display = clear_q;
  assign o_lcd_wr_text_line     = line_q;
  assign o_lcd_line_index       = idx_q;
  assign o_lcd_feed_is_idle     = idle_q;
  assign o_refresh_count        = count_q;
`ifdef LCD_FEED_CMD_TIMEOUT_EN
  assign o_cmd_timeout          = timeout_q;
`else
  assign o_cmd_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_multi_line_feed.sv
// Scoreboard bench for lcd_multi_line_feed: expected commands queued per refresh cycle, checked on each write.
module tb_lcd_multi_line_feed;

  localparam int LINES = 4;
  localparam int DLY   = 5;
  localparam int REF   = 12;
  localparam int TOUT  = 100;
  localparam int LIMIT = 80000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       ready = 1'b1;
  logic       en = 1'b0;
  logic       req = 1'b0;
  logic       clr_o;
  logic [3:0] line_o;
  logic [1:0] idx_o;
  logic       idle_o;
  logic [7:0] cnt_o;
  logic       tout_o;

  lcd_multi_line_feed #(
    .parm_line_count      (LINES),
    .parm_cmd_delay_ticks (DLY),
    .parm_refresh_ticks   (REF),
    .parm_timeout_ticks   (TOUT)
  ) dut (
    .i_clk_20mhz            (clk),
    .i_rst_20mhz            (rst),
    .i_ce_2_5mhz            (ce),
    .i_lcd_command_ready    (ready),
    .i_feed_enable          (en),
    .i_refresh_request      (req),
    .o_lcd_wr_clear_display (clr_o),
    .o_lcd_wr_text_line     (line_o),
    .o_lcd_line_index       (idx_o),
    .o_lcd_feed_is_idle     (idle_o),
    .o_refresh_count        (cnt_o),
    .o_cmd_timeout          (tout_o)
  );

  typedef struct {int code; int gap;} exp_t;
  exp_t sb[$];

  int   n_err = 0;
  int   n_checks = 0;
  int   idle_falls = 0;
  int   idle_rises = 0;
  int   idle_cnt = 0;
  int   idle_len = 0;
  logic [7:0] exp_count = '0;
  logic hold_ready = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    ce = ~ce;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_cycle(input int clear_gap);
    exp_t e;
    e.code = 0; e.gap = clear_gap;
    sb.push_back(e);
    for (int k = 0; k < LINES; k++) begin
      e.code = k + 1; e.gap = DLY + 1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_falls(input int n);
    int t = 0;
    while (idle_falls < n && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check("wait_idle_fall", idle_falls, n);
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (idle_rises < n && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check("wait_idle_rise", idle_rises, n);
  endtask

  task automatic wait_sb(input int n);
    int t = 0;
    while (sb.size() > n && t < LIMIT) begin @(negedge clk); t++; end
    if (t >= LIMIT) check("wait_queue", sb.size(), n);
  endtask

  // Driver acknowledge model: drops ready for 3 ce ticks per accepted command.
  initial begin
    int busy = 0;
    forever begin
      @(negedge clk);
      if (busy > 0) begin
        if (ce) busy--;
        if (busy == 0) ready = 1'b1;
      end else if ((clr_o || line_o != 0) && ready && !hold_ready) begin
        ready = 1'b0;
        busy  = 3;
      end
    end
  end

  // Monitor: pops the scoreboard on every new write request, tracks idle periods.
  initial begin
    logic [4:0] wr, prev_wr;
    logic       prev_idle;
    int         gap, code;
    exp_t       it;
    prev_wr = '0; prev_idle = 1'b0; gap = 0;
    forever begin
      @(negedge clk);
      wr = {line_o, clr_o};
      if (rst) begin
        prev_wr = wr; prev_idle = idle_o; gap = 0;
        continue;
      end
      if (wr != 0 && prev_wr == 0) begin
        check("onehot", $countones(wr), 1);
        code = 0;
        for (int k = 0; k < 5; k++) if (wr[k]) code = k;
        if (sb.size() == 0) begin
          check("unexpected_write", code, 99);
        end else begin
          it = sb.pop_front();
          check("cmd_order", code, it.code);
          if (code > 0) check("line_index", idx_o, code - 1);
          if (it.gap >= 0) check("cmd_gap", gap, it.gap);
        end
        gap = 0;
      end else if (idle_o) begin
        gap = 0;
      end else if (ce && wr == 0) begin
        gap++;
      end
      if (idle_o && !prev_idle) begin
        idle_cnt = 0;
        idle_rises++;
        exp_count = exp_count + 8'd1;
        check("refresh_count", cnt_o, exp_count);
      end
      if (idle_o && ce) idle_cnt++;
      if (!idle_o && prev_idle) begin
        idle_len = idle_cnt;
        idle_falls++;
      end
      prev_wr = wr; prev_idle = idle_o;
    end
  end

  initial begin
    int t;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_clear", clr_o, 0);
    check("rst_line", line_o, 0);
    check("rst_index", idx_o, 0);
    check("rst_idle", idle_o, 0);
    check("rst_count", cnt_o, 0);
    check("rst_timeout", tout_o, 0);
    rst = 1'b0;

    // Two full cycles; enable dropped during line 0 of the second.
    push_cycle(-1);
    push_cycle(1);
    en = 1'b1;
    wait_falls(1);
    check("idle_len", idle_len, REF);
    wait_sb(LINES - 1);
    en = 1'b0;
    wait_falls(2);
    check("idle_len2", idle_len, REF);
    repeat (100) @(negedge clk);
    check("paused_no_clear", clr_o, 0);
    check("paused_queue", sb.size(), 0);
    check("paused_count", cnt_o, 2);

    // Early refresh request 10 ticks into the hold.
    push_cycle(-1);
    push_cycle(1);
    en = 1'b1;
    wait_rises(3);
    t = 0;
    while (idle_cnt < 10 && t < LIMIT) begin @(posedge clk); #1; t++; end
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_falls(3);
    check("early_refresh_len", idle_len, 11);
    wait_falls(4);
    check("idle_len4", idle_len, REF);

    // Run to the 256th cycle so the counter wraps.
    for (int c = 0; c < 253; c++) push_cycle(1);
    wait_rises(256);
    check("count_wrap", cnt_o, 0);

    // Reset during line 0 delay.
    wait_sb(LINES - 1);
    t = 0;
    while (line_o != 0 && t < LIMIT) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_clear", clr_o, 0);
    check("mid_rst_line", line_o, 0);
    check("mid_rst_idle", idle_o, 0);
    check("mid_rst_count", cnt_o, 0);
    check("mid_rst_index", idx_o, 0);
    sb.delete();
    exp_count = '0;
    en = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

`ifdef LCD_FEED_CMD_TIMEOUT_EN
    begin
      exp_t e;
      int   n = 0;
      e.code = 0; e.gap = -1;
      sb.push_back(e);
      hold_ready = 1'b1;
      en = 1'b1;
      t = 0;
      while (!tout_o && t < LIMIT) begin
        @(negedge clk);
        t++;
        if (clr_o) begin
          en = 1'b0;
          if (ce) n++;
        end
      end
      check("timeout_ticks", n, TOUT);
      check("timeout_pulse", tout_o, 1);
      check("timeout_clear_low", clr_o, 0);
      check("timeout_count", cnt_o, 0);
      hold_ready = 1'b0;
    end
`else
    check("timeout_tied", tout_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_multi_line_feed.md
Name: lcd_multi_line_feed

Overview:
Parametrised timed Moore FSM that repeatedly feeds display-refresh commands to the LCD command driver. Each refresh cycle is: clear, then write lines 0..N-1 in order, then a refresh hold. Line count and all delays are parameters. Adds an enable gate, an early-refresh request, a line-index output and a refresh counter. Sits between the top-level text formatter and the PMOD CLS SPI command driver, in the 20 MHz domain, and is stepped by the 2.5 MHz clock enable.

Parameters:
parm_line_count, 2, number of text lines written per refresh cycle; legal range 1..4.
parm_cmd_delay_ticks, 2500, ce ticks held after each accepted command (1 ms at 2.5 MHz); must be >= 1.
parm_refresh_ticks, 490000, ce ticks held after the last line is accepted, before the next cycle; must be >= 1.
parm_timeout_ticks, 25000, ce ticks a RUN state may wait for an acknowledge; used only with the optional feature.

Ports:
i_clk_20mhz  in  1  system clock.
i_rst_20mhz  in  1  synchronous active-high reset.
i_ce_2_5mhz  in  1  clock enable; the FSM and timer advance only when this is high.
i_lcd_command_ready  in  1  driver ready; low means a command is in progress (acknowledge).
i_feed_enable  in  1  permits a new refresh cycle to start.
i_refresh_request  in  1  single-clock pulse that shortens the current refresh hold.
o_lcd_wr_clear_display  out  1  clear-display command request.
o_lcd_wr_text_line  out  4  one-hot line write request; bit k writes line k; bits >= parm_line_count are always 0.
o_lcd_line_index  out  2  index of the line currently being written or held.
o_lcd_feed_is_idle  out  1  high while in ST_REFRESH_DLY.
o_refresh_count  out  8  number of completed refresh cycles; wraps 255 -> 0.
o_cmd_timeout  out  1  single-ce-tick timeout pulse (optional feature).

Behaviour:
- Reset: state ST_PAUSE; timer, line index, refresh flag and refresh count all 0; every output 0.
- State register and timer update only on clocks where i_ce_2_5mhz=1. Outputs are decoded from the present state only (Moore).
- Timer (24 bits): on a ce tick it clears when the next state differs from the present state; otherwise it increments, saturating at the larger of the two delay parameters.
- ST_PAUSE: leave to ST_CLEAR_RUN when i_feed_enable=1 and ready=1; otherwise stay.
- ST_CLEAR_RUN: clear=1. Leave to ST_CLEAR_DLY when ready=0.
- ST_CLEAR_DLY: leave to ST_CLEAR_WAIT when timer == parm_cmd_delay_ticks-1.
- ST_CLEAR_WAIT: when ready=1, set line index to 0 and go to ST_LINE_RUN.
- ST_LINE_RUN: o_lcd_wr_text_line[idx]=1. Leave to ST_LINE_DLY when ready=0.
- ST_LINE_DLY: when timer == parm_cmd_delay_ticks-1:
  - if idx < parm_line_count-1, go to ST_LINE_WAIT;
  - otherwise go to ST_REFRESH_DLY and increment o_refresh_count.
- ST_LINE_WAIT: when ready=1, increment idx and go to ST_LINE_RUN.
- ST_REFRESH_DLY: go to ST_PAUSE when timer == parm_refresh_ticks-1, or at the first ce tick while the refresh flag is set.
- Refresh flag:
  - set by i_refresh_request on any clock, regardless of ce;
  - cleared on entering ST_CLEAR_RUN;
  - if set and clear occur on the same clock, set wins.
- i_feed_enable is sampled only in ST_PAUSE. Deasserting it mid-cycle lets the current cycle complete, then holds in ST_PAUSE.
- At most one write output is high at any time.
- o_lcd_line_index holds its value through ST_REFRESH_DLY and ST_PAUSE.
- parm_line_count=1: the cycle is clear, line 0, refresh hold.
- Reset asserted mid-operation returns to the reset state on the next clock, regardless of ce.

Optional Feature:
LCD_FEED_CMD_TIMEOUT_EN:
- Defined: in any RUN state, if ready has stayed 1 for parm_timeout_ticks ce ticks, the FSM goes to ST_PAUSE and o_cmd_timeout is high for one ce tick. The refresh count is not incremented.
- Not defined: o_cmd_timeout is tied 0 and RUN states wait indefinitely.

Test Plan:
- Reset, enable=1, ready model drops ready for 10 ticks per command, parm_line_count=2 -> sequence clear, line[0], line[1]; each DLY lasts 2500 ticks; idle high for 490000 ticks; refresh_count=1.
- parm_line_count=4 -> write bits 0,1,2,3 in order with line_index 0..3; exactly 4 line pulses per cycle.
- refresh_request pulse 100 ticks into ST_REFRESH_DLY -> ST_PAUSE on the next ce tick; the new cycle starts with clear.
- enable=0 asserted during line 0 -> cycle completes; FSM remains in ST_PAUSE with no clear until enable=1.
- Reset asserted during ST_LINE_DLY -> next clock shows all outputs 0 and refresh_count=0; 256 completed cycles -> refresh_count wraps to 0.
- With LCD_FEED_CMD_TIMEOUT_EN defined and parm_timeout_ticks=100, ready held 1 in ST_CLEAR_RUN -> o_cmd_timeout pulses at tick 100; state ST_PAUSE; refresh_count unchanged.
